ship_motion_ctrl: RTL and testbench
===================================

SHIP_MOTION_CTRL -- requirements
Module: ship_motion_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  X_START 320, reset x position; Y_START 240, reset y position
  X_MAX 639, max x (min 0); Y_MAX 479, max y (min 0)
  SPEED_MAX 4, max pixels per frame per axis
  ACCEL_FRAMES 8, frames per speed step; ROT_FRAMES 4, frames per 45-degree turn
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  Clk  in  1  system clock, sole clock
  Reset_n  in  1  reset, asynchronous, active-low
  frame_clk  in  1  vertical-sync frame signal, asynchronous to Clk, sampled as data
  keycode  in  8  current USB keycode
  pos_x  out  10  ship x position
  pos_y  out  10  ship y position
  dir  out  3  heading: 0=N,1=NE,2=E,3=SE,4=S,5=SW,6=W,7=NW
  speed  out  3  current speed, 0..SPEED_MAX
  moving  out  1  high when speed != 0

Function
REQ-003 SHALL synchronize frame_clk through two flops; the rising edge of the synchronized signal produces frame_tick, high for exactly one Clk cycle, 3 cycles after the frame_clk rising edge.
REQ-004 SHALL sample keycode only on frame_tick; decode: 8'h1A->req N(0), 8'h16->S(4), 8'h04->W(6), 8'h07->E(2); any other value is no-key.
REQ-005 SHALL update all outputs only in the cycle after frame_tick; between ticks, outputs hold.
REQ-006 Speed FSM SHALL have states IDLE, ACCEL, CRUISE, DECEL, evaluated on frame_tick.
REQ-007 IDLE: speed 0; valid key -> ACCEL.
REQ-008 ACCEL: accel counter increments per tick; when it reaches ACCEL_FRAMES-1, speed+1 and counter clears; speed reaching SPEED_MAX -> CRUISE; no-key -> DECEL, counter cleared.
REQ-009 CRUISE: speed holds SPEED_MAX; no-key -> DECEL, counter cleared.
REQ-010 DECEL: speed-1 every ACCEL_FRAMES ticks; speed reaching 0 -> IDLE; valid key -> ACCEL, counter cleared, speed retained.
REQ-011 Speed SHALL saturate at 0 and SPEED_MAX, never wrap.
REQ-012 Heading: on a tick with valid key, diff=(req-dir) mod 8; diff 0 -> rotation counter clears; otherwise the counter increments; at ROT_FRAMES-1, dir steps +1 (diff 1..4; diff 4 turns clockwise) or -1 (diff 5..7) mod 8, and the counter clears. No-key holds dir and the counter.
REQ-013 Per tick, position SHALL move by speed on each nonzero axis component of dir (N: y-; E: x+; diagonals both axes), using dir and speed values from before the tick.
REQ-014 Position arithmetic SHALL use 11-bit signed intermediates and clamp to [0,X_MAX]/[0,Y_MAX]; hitting a bound does not change speed or state.
REQ-015 moving SHALL equal (speed != 0) combinationally from the speed register.
REQ-016 Speed and heading updates on the same tick SHALL be independent; keycode changes between ticks SHALL have no effect.

Reset
REQ-017 Reset_n low SHALL immediately force pos_x=X_START, pos_y=Y_START, dir=0, speed=0, moving=0, state IDLE, all counters and sync flops 0.
REQ-018 Reset mid-motion SHALL abandon any ramp or turn; the first tick after release is treated as a fresh edge only if synchronized frame_clk rises after release.

Structure
REQ-019 Package ship_pkg SHALL hold dir_t (3-bit enum), motion_state_t enum, and the keycode constants KEY_W/KEY_A/KEY_S/KEY_D.
REQ-020 Sub-module frame_tick_sync (two-flop synchronizer + rising-edge detector) SHALL produce frame_tick; all other logic stays in ship_motion_ctrl.

Verification
REQ-021 Reset, keycode 8'h07 held 40 ticks -> dir steps 0->1->2 at ticks 4 and 8 (ROT_FRAMES=4), speed reaches 4 at tick 32, state CRUISE, moving=1.
REQ-022 From CRUISE heading E at x=630, continue 8'h07 -> pos_x clamps at 639, speed stays 4.
REQ-023 From CRUISE, keycode 8'h00 -> speed drops one step every 8 ticks, reaching 0 after 32 ticks; moving falls the cycle after; state IDLE; position frozen.
REQ-024 dir=0, keycode 8'h16 (diff 4) -> dir goes 1,2,3,4 (clockwise), one step per 4 ticks.
REQ-025 DECEL at speed 2, keycode 8'h1A -> ACCEL resumes from speed 2, not 0.
REQ-026 Assert Reset_n low mid-ACCEL with pos_x=400 -> same-cycle pos_x=320, speed=0, dir=0; frame_clk toggling during reset produces no tick.

Source files
------------

// File: rtl/ship_pkg.sv
// Shared types and keycode constants for the ship motion controller.
package ship_pkg;

    // Eight compass headings, clockwise from north.
    typedef enum logic [2:0] {
        DirN  = 3'd0,
        DirNe = 3'd1,
        DirE  = 3'd2,
        DirSe = 3'd3,
        DirS  = 3'd4,
        DirSw = 3'd5,
        DirW  = 3'd6,
        DirNw = 3'd7
    } dir_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccel,
        StCruise,
        StDecel
    } motion_state_t;

    // USB HID keycodes for the four steering keys.
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_req_t;

    // Map a keycode onto a requested heading; anything else is "no key".
    function automatic key_req_t key_decode(input logic [7:0] key);
        key_req_t r;
        r.valid = 1'b1;
        r.dir   = DirN;
        case (key)
            KEY_W:   r.dir = DirN;
            KEY_S:   r.dir = DirS;
            KEY_A:   r.dir = DirW;
            KEY_D:   r.dir = DirE;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame signal into the Clk domain and emits a
// single-cycle pulse on each rising edge, three Clk edges after the input rises.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1, sync2, sync2_prev, tick_q;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync2_prev <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync2_prev <= sync2;
            tick_q     <= sync2 & ~sync2_prev;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/ship_motion_ctrl.sv
// Keyboard-driven ship: per-frame speed ramp, gradual heading turns and
// clamped position integration. All state advances only on frame ticks.
module ship_motion_ctrl
    import ship_pkg::*;
#(
    parameter int unsigned X_START      = 320,
    parameter int unsigned Y_START      = 240,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MAX        = 479,
    parameter int unsigned SPEED_MAX    = 4,
    parameter int unsigned ACCEL_FRAMES = 8,
    parameter int unsigned ROT_FRAMES   = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [2:0] dir,
    output logic [2:0] speed,
    output logic       moving
);

    localparam int unsigned ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int unsigned ROT_W = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_FRAMES - 1);
    localparam logic [2:0] SPD_TOP = 3'(SPEED_MAX);
    localparam logic signed [10:0] X_TOP = 11'(X_MAX);
    localparam logic signed [10:0] Y_TOP = 11'(Y_MAX);

    logic             frame_tick;
    key_req_t         req;
    motion_state_t    state_q;
    logic [2:0]       speed_q;
    logic [ACC_W-1:0] acc_cnt_q;
    dir_t             dir_q;
    logic [ROT_W-1:0] rot_cnt_q;
    logic [9:0]       pos_x_q, pos_y_q;

    frame_tick_sync u_sync (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    assign req = key_decode(keycode);

    logic             do_accel, do_decel, acc_step;
    logic [ACC_W-1:0] acc_base;

    // Pick the ramp direction and the frame count it continues from.
    always_comb begin
        do_accel = req.valid && (state_q != StCruise);
        do_decel = !req.valid && (state_q != StIdle);
        // Entering a ramp restarts the count; the entry frame is its first frame.
        if ((do_accel && state_q != StAccel) || (do_decel && state_q != StDecel)) begin
            acc_base = '0;
        end else begin
            acc_base = acc_cnt_q;
        end
        acc_step = (acc_base == ACC_LAST);
    end

    // Speed FSM: IDLE/ACCEL/CRUISE/DECEL, stepping speed once per ACCEL_FRAMES frames.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            speed_q   <= '0;
            acc_cnt_q <= '0;
        end else if (frame_tick) begin
            if (do_accel) begin
                if (acc_step) begin
                    acc_cnt_q <= '0;
                    if (speed_q >= SPD_TOP - 3'd1) begin
                        speed_q <= SPD_TOP;
                        state_q <= StCruise;
                    end else begin
                        speed_q <= speed_q + 3'd1;
                        state_q <= StAccel;
                    end
                end else begin
                    acc_cnt_q <= acc_base + ACC_W'(1);
                    state_q   <= StAccel;
                end
            end else if (do_decel) begin
                if (acc_step) begin
                    acc_cnt_q <= '0;
                    if (speed_q <= 3'd1) begin
                        speed_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        speed_q <= speed_q - 3'd1;
                        state_q <= StDecel;
                    end
                end else begin
                    acc_cnt_q <= acc_base + ACC_W'(1);
                    state_q   <= StDecel;
                end
            end
        end
    end

    logic [2:0] diff;
    assign diff = req.dir - dir_q;

    // Heading turns one 45-degree step per ROT_FRAMES frames toward the request.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_q     <= DirN;
            rot_cnt_q <= '0;
        end else if (frame_tick && req.valid) begin
            if (diff == 3'd0) begin
                rot_cnt_q <= '0;
            end else if (rot_cnt_q == ROT_LAST) begin
                rot_cnt_q <= '0;
                // A reversal (diff 4) resolves clockwise.
                dir_q <= (diff <= 3'd4) ? dir_t'(dir_q + 3'd1) : dir_t'(dir_q - 3'd1);
            end else begin
                rot_cnt_q <= rot_cnt_q + ROT_W'(1);
            end
        end
    end

    logic signed [10:0] step, x_sum, y_sum;
    logic [9:0]         x_next, y_next;

    // Integrate the pre-tick speed along the pre-tick heading, then clamp.
    always_comb begin
        step  = $signed({8'b0, speed_q});
        x_sum = $signed({1'b0, pos_x_q});
        y_sum = $signed({1'b0, pos_y_q});
        unique case (dir_q)
            DirNe, DirE, DirSe: x_sum = x_sum + step;
            DirSw, DirW, DirNw: x_sum = x_sum - step;
            default: ;
        endcase
        unique case (dir_q)
            DirSe, DirS, DirSw: y_sum = y_sum + step;
            DirNw, DirN, DirNe: y_sum = y_sum - step;
            default: ;
        endcase
        if (x_sum < 11'sd0)     x_next = '0;
        else if (x_sum > X_TOP) x_next = X_TOP[9:0];
        else                    x_next = x_sum[9:0];
        if (y_sum < 11'sd0)     y_next = '0;
        else if (y_sum > Y_TOP) y_next = Y_TOP[9:0];
        else                    y_next = y_sum[9:0];
    end

    // Position register, loaded once per frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x_q <= 10'(X_START);
            pos_y_q <= 10'(Y_START);
        end else if (frame_tick) begin
            pos_x_q <= x_next;
            pos_y_q <= y_next;
        end
    end

    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;
    assign dir    = dir_q;
    assign speed  = speed_q;
    assign moving = (speed_q != 3'd0);

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Directed bench for ship_motion_ctrl with a frame-level reference model
// feeding an expected-output queue.
module tb_ship_motion_ctrl;

    localparam logic [7:0] K_UP    = 8'h1A;
    localparam logic [7:0] K_DOWN  = 8'h16;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_NONE  = 8'h00;
    localparam int AF   = 8;
    localparam int RF   = 4;
    localparam int SMAX = 4;
    localparam int ST_IDLE = 0, ST_ACCEL = 1, ST_CRUISE = 2, ST_DECEL = 3;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] pos_x, pos_y;
    logic [2:0] dir, speed;
    logic       moving;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;
    logic [26:0] sb[$];

    int m_x, m_y, m_dir, m_spd, m_st, m_acc, m_rot;

    ship_motion_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .dir       (dir),
        .speed     (speed),
        .moving    (moving)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_x = 320; m_y = 240; m_dir = 0; m_spd = 0; m_st = ST_IDLE; m_acc = 0; m_rot = 0;
    endtask

    task automatic ramp_up();
        m_st = ST_ACCEL;
        if (m_acc == AF - 1) begin
            m_acc = 0;
            m_spd = m_spd + 1;
            if (m_spd >= SMAX) begin
                m_spd = SMAX;
                m_st  = ST_CRUISE;
            end
        end else begin
            m_acc = m_acc + 1;
        end
    endtask

    task automatic ramp_down();
        m_st = ST_DECEL;
        if (m_acc == AF - 1) begin
            m_acc = 0;
            m_spd = m_spd - 1;
            if (m_spd <= 0) begin
                m_spd = 0;
                m_st  = ST_IDLE;
            end
        end else begin
            m_acc = m_acc + 1;
        end
    endtask

    task automatic model_tick(input logic [7:0] key);
        int req, dx, dy, diff;
        bit valid;
        valid = 1'b1;
        req   = 0;
        case (key)
            8'h1A:   req = 0;
            8'h16:   req = 4;
            8'h04:   req = 6;
            8'h07:   req = 2;
            default: valid = 1'b0;
        endcase
        // Motion uses heading and speed from before this frame.
        dx = (m_dir >= 1 && m_dir <= 3) ? 1 : ((m_dir >= 5) ? -1 : 0);
        dy = (m_dir >= 3 && m_dir <= 5) ? 1 : ((m_dir == 7 || m_dir <= 1) ? -1 : 0);
        m_x = m_x + dx * m_spd;
        m_y = m_y + dy * m_spd;
        if (m_x < 0) m_x = 0;
        if (m_x > 639) m_x = 639;
        if (m_y < 0) m_y = 0;
        if (m_y > 479) m_y = 479;
        if (valid) begin
            diff = (req - m_dir + 8) % 8;
            if (diff == 0) begin
                m_rot = 0;
            end else if (m_rot == RF - 1) begin
                m_rot = 0;
                m_dir = (diff <= 4) ? (m_dir + 1) % 8 : (m_dir + 7) % 8;
            end else begin
                m_rot = m_rot + 1;
            end
        end
        case (m_st)
            ST_IDLE:   if (valid) begin m_acc = 0; ramp_up(); end
            ST_ACCEL:  if (valid) ramp_up(); else begin m_acc = 0; ramp_down(); end
            ST_CRUISE: if (!valid) begin m_acc = 0; ramp_down(); end
            default:   if (valid) begin m_acc = 0; ramp_up(); end else ramp_down();
        endcase
    endtask

    function automatic logic [26:0] snap();
        return {10'(m_x), 10'(m_y), 3'(m_dir), 3'(m_spd), (m_spd != 0)};
    endfunction

    task automatic check_out(input string tag);
        logic [26:0] exp, obs;
        exp = sb.pop_front();
        obs = {pos_x, pos_y, dir, speed, moving};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got x=%0d y=%0d dir=%0d spd=%0d mov=%0d, want x=%0d y=%0d dir=%0d spd=%0d mov=%0d",
                    tag, obs[26:17], obs[16:7], obs[6:4], obs[3:1], obs[0],
                    exp[26:17], exp[16:7], exp[6:4], exp[3:1], exp[0]);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // One frame: outputs must hold until the 4th edge after frame_clk rises.
    task automatic frame(input logic [7:0] key);
        sb.push_back(snap());
        model_tick(key);
        sb.push_back(snap());
        frame_no++;
        keycode   = key;
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check_out($sformatf("hold_f%0d", frame_no));
        @(posedge Clk);
        #1 check_out($sformatf("tick_f%0d", frame_no));
        frame_clk = 1'b0;
        keycode   = 8'h04;  // junk between frames must be ignored
        repeat (4) @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = K_NONE;
        model_reset();
        repeat (2) begin
            frame_clk = 1'b1;
            repeat (3) @(posedge Clk);
            frame_clk = 1'b0;
            repeat (3) @(posedge Clk);
        end
        #1;
        chk("rst_x", pos_x, 320);
        chk("rst_y", pos_y, 240);
        chk("rst_dir", dir, 0);
        chk("rst_spd", speed, 0);
        chk("rst_mov", moving, 0);
        Reset_n = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        sb.push_back(snap());
        check_out("post_release");

        // Hold east: two turns then a full ramp to cruise.
        for (int i = 1; i <= 40; i++) begin
            frame(K_RIGHT);
            if (i == 3)  chk("dir_f3", dir, 0);
            if (i == 4)  chk("dir_f4", dir, 1);
            if (i == 8)  chk("dir_f8", dir, 2);
            if (i == 31) chk("spd_f31", speed, 3);
            if (i == 32) chk("spd_f32", speed, 4);
        end
        chk("cruise_spd", speed, 4);
        chk("cruise_mov", moving, 1);

        // Keep going east into the right edge.
        for (int i = 0; i < 100; i++) frame(K_RIGHT);
        chk("clamp_x", pos_x, 639);
        chk("clamp_y", pos_y, 240);
        chk("clamp_spd", speed, 4);

        // Release: one speed step down per 8 frames.
        for (int i = 1; i <= 32; i++) begin
            frame(K_NONE);
            if (i == 8)  chk("decel_f8", speed, 3);
            if (i == 31) chk("decel_f31", speed, 1);
            if (i == 32) chk("decel_mov", moving, 0);
        end
        for (int i = 0; i < 4; i++) frame(K_NONE);
        chk("frozen_x", pos_x, 639);

        // Turn back to north, then request south: clockwise through E.
        for (int i = 0; i < 8; i++) frame(K_UP);
        chk("north_dir", dir, 0);
        for (int i = 1; i <= 16; i++) begin
            frame(K_DOWN);
            if (i % 4 == 0) chk($sformatf("cw_f%0d", i), dir, i / 4);
        end
        chk("ramp_spd3", speed, 3);

        // Drop to speed 2 in DECEL, then resume accelerating from 2.
        for (int i = 0; i < 8; i++) frame(K_NONE);
        chk("decel_at2", speed, 2);
        frame(K_UP);
        chk("resume_keep2", speed, 2);
        for (int i = 0; i < 7; i++) frame(K_UP);
        chk("resume_spd3", speed, 3);

        // Asynchronous reset mid-ramp; frame pulses under reset are ignored.
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("arst_x", pos_x, 320);
        chk("arst_y", pos_y, 240);
        chk("arst_dir", dir, 0);
        chk("arst_spd", speed, 0);
        chk("arst_mov", moving, 0);
        repeat (3) begin
            frame_clk = 1'b1;
            repeat (4) @(posedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(posedge Clk);
        end
        #1 Reset_n = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        model_reset();
        sb.push_back(snap());
        check_out("arst_release");
        for (int i = 0; i < 9; i++) frame(K_RIGHT);
        chk("fresh_spd", speed, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
